// File: rtl/alu.sv
// rtl/alu.sv - 32-bit registered ALU with operand muxes and registered zero flag
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] Ext,
  input  logic [31:0] Sa,
  input  logic [2:0]  ALUop,
  input  logic        ALUSrcA,
  input  logic        ALUSrcB,
  output logic [31:0] Result,
  output logic        zero
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] next_result;

  always_comb begin
    a = ALUSrcA ? Sa : ReadData1;
    b = ALUSrcB ? Ext : ReadData2;
  end

  always_comb begin
    next_result = 32'd0;
    case (ALUop)
      OP_ADD:  next_result = a + b;
      OP_SUB:  next_result = a - b;
      // Only the low five bits of A form the shift distance.
      OP_SLL:  next_result = b << a[4:0];
      OP_OR:   next_result = a | b;
      OP_AND:  next_result = a & b;
      OP_SLTU: next_result = (a < b) ? 32'd1 : 32'd0;
      OP_SLT:  next_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR:  next_result = ~(a | b);
      default: next_result = 32'd0;
    endcase
  end

  // zero is registered alongside Result so the two never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      Result <= 32'd0;
      zero   <= 1'b1;
    end else begin
      Result <= next_result;
      zero   <= (next_result == 32'd0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed and randomized self-checking bench for alu
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] Ext;
  logic [31:0] Sa;
  logic [2:0]  ALUop;
  logic        ALUSrcA;
  logic        ALUSrcB;
  logic [31:0] Result;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  alu dut (
    .clk(clk), .rst(rst),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Ext(Ext), .Sa(Sa),
    .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .Result(Result), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'd0, x});
    longint uy = longint'({32'd0, y});
    case (op)
      3'd0: return 32'(ux + uy);
      3'd1: return 32'(ux - uy);
      3'd2: return 32'(uy * (longint'(1) << (ux % 32)));
      3'd3: return x | y;
      3'd4: return x & y;
      3'd5: return (ux < uy) ? 32'd1 : 32'd0;
      3'd6: return (sx < sy) ? 32'd1 : 32'd0;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] exp_r, input logic exp_z);
    n_cmp++;
    assert (Result === exp_r) else begin
      n_err++;
      $error("FAIL %s Result: got %h expected %h", tag, Result, exp_r);
    end
    n_cmp++;
    assert (zero === exp_z) else begin
      n_err++;
      $error("FAIL %s zero: got %b expected %b", tag, zero, exp_z);
    end
  endtask

  task automatic drive(input bit sa_sel, input bit sb_sel, input logic [2:0] op,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] e, input logic [31:0] s);
    ALUSrcA = sa_sel; ALUSrcB = sb_sel; ALUop = op;
    ReadData1 = r1; ReadData2 = r2; Ext = e; Sa = s;
  endtask

  task automatic run(input string tag, input bit sa_sel, input bit sb_sel,
                     input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] e, input logic [31:0] s, input logic [31:0] exp_r);
    drive(sa_sel, sb_sel, op, r1, r2, e, s);
    @(posedge clk); #1;
    check(tag, exp_r, exp_r == 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 32'd7, 32'd9, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("reset_state", 32'd0, 1'b1);
    rst = 1'b0;

    run("add_00", 0, 0, 3'b000, 0, 0, 1, 1, 32'd0);
    run("add_10", 1, 0, 3'b000, 0, 0, 1, 1, 32'd1);
    run("add_01", 0, 1, 3'b000, 0, 0, 1, 1, 32'd1);
    run("add_11", 1, 1, 3'b000, 0, 0, 1, 1, 32'd2);

    run("sub_00", 0, 0, 3'b001, 1, 2, 3, 4, 32'hFFFF_FFFF);
    run("sub_10", 1, 0, 3'b001, 1, 2, 3, 4, 32'd2);
    run("sub_01", 0, 1, 3'b001, 1, 2, 3, 4, 32'hFFFF_FFFE);
    run("sub_11", 1, 1, 3'b001, 1, 2, 3, 4, 32'd1);

    run("sll_00",  0, 0, 3'b010, 1, 2, 2, 4, 32'd4);
    run("sll_11",  1, 1, 3'b010, 1, 2, 2, 4, 32'd32);
    run("sll_a33", 0, 0, 3'b010, 33, 2, 0, 0, 32'd4);
    run("sll_a31", 0, 0, 3'b010, 31, 1, 0, 0, 32'h8000_0000);

    run("or_00",  0, 0, 3'b011, 1, 2, 2, 4, 32'd3);
    run("and_00", 0, 0, 3'b100, 1, 2, 2, 4, 32'd0);
    run("nor_00", 0, 0, 3'b111, 1, 2, 2, 4, 32'hFFFF_FFFC);
    run("or_11",  1, 1, 3'b011, 1, 2, 2, 4, 32'd6);
    run("and_11", 1, 1, 3'b100, 1, 2, 2, 4, 32'd0);
    run("nor_11", 1, 1, 3'b111, 1, 2, 2, 4, 32'hFFFF_FFF9);

    run("sltu_1_2",  0, 0, 3'b101, 1, 2, 0, 0, 32'd1);
    run("slt_1_2",   0, 0, 3'b110, 1, 2, 0, 0, 32'd1);
    run("sltu_m1_1", 0, 0, 3'b101, 32'hFFFF_FFFF, 1, 0, 0, 32'd0);
    run("slt_m1_1",  0, 0, 3'b110, 32'hFFFF_FFFF, 1, 0, 0, 32'd1);
    run("sltu_eq",   0, 0, 3'b101, 5, 5, 0, 0, 32'd0);
    run("slt_eq",    0, 0, 3'b110, 5, 5, 0, 0, 32'd0);

    // Reset held during an add, then released.
    rst = 1'b1;
    drive(0, 0, 3'b000, 1, 1, 0, 0);
    @(posedge clk); #1;
    check("rst_hold_add", 32'd0, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_add", 32'd2, 1'b0);

    // Single-edge reset between two valid operations.
    run("pre_pulse", 0, 0, 3'b011, 32'h10, 32'h01, 0, 0, 32'h11);
    rst = 1'b1;
    drive(0, 0, 3'b000, 32'd100, 32'd23, 0, 0);
    @(posedge clk); #1;
    check("rst_pulse", 32'd0, 1'b1);
    rst = 1'b0;
    run("post_pulse", 0, 0, 3'b000, 32'd100, 32'd23, 0, 0, 32'd123);

    for (int i = 0; i < 300; i++) begin
      logic [2:0]  op;
      logic [31:0] r1, r2, e, s, x, y;
      bit sa_sel, sb_sel;
      op = 3'($urandom_range(0, 7));
      sa_sel = 1'($urandom_range(0, 1));
      sb_sel = 1'($urandom_range(0, 1));
      r1 = $urandom; r2 = $urandom; e = $urandom;
      s = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) r2 = r1;
      if ($urandom_range(0, 7) == 0) e = s;
      x = sa_sel ? s : r1;
      y = sb_sel ? e : r2;
      run($sformatf("rand_%0d_op%0d", i, op), sa_sel, sb_sel, op, r1, r2, e, s,
          model(op, x, y));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
